// File: rtl/flex_down_timer.sv
// Loadable, pausable down-counting timer with one-shot or periodic reload.
// Pulses tick on reaching zero; done holds after a one-shot run completes.
module flex_down_timer #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] load_val,
  input  logic            auto_reload,
  input  logic            pause,
  input  logic            abort,
  output logic [SIZE-1:0] count_out,
  output logic            tick,
  output logic            done,
  output logic            busy
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] RUN    = 2'b01;
  localparam logic [1:0] PAUSED = 2'b10;
  localparam logic [1:0] DONE   = 2'b11;

  logic [1:0]      state;
  logic [SIZE-1:0] count;
  logic [SIZE-1:0] reload_reg;
  logic            at_zero;

  assign at_zero = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
    end else if (abort) begin
      state <= IDLE;
      count <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            reload_reg <= load_val;
            count      <= load_val;
            state      <= RUN;
          end else begin
            count <= '0;
          end
        end
        RUN: begin
          // the zero cycle is the tick; pause cannot stretch it
          if (at_zero) begin
            if (auto_reload) begin
              count <= reload_reg;
            end else begin
              state <= DONE;
            end
          end else if (pause) begin
            state <= PAUSED;
          end else begin
            count <= count - 1'b1;
          end
        end
        PAUSED: begin
          if (!pause) begin
            state <= RUN;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  assign count_out = count;
  assign tick      = (state == RUN) && at_zero;
  assign done      = (state == DONE);
  assign busy      = (state == RUN) || (state == PAUSED);

endmodule

// File: tb/tb_flex_down_timer.sv
// Directed bench for flex_down_timer: stimulus pushes hand-computed
// expectations, a monitor pops and compares one per clock.
module tb_flex_down_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       auto_reload = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] count_out;
  logic       tick;
  logic       done;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [6:0] exp_q[$];
  string      name_q[$];

  flex_down_timer #(.SIZE(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .load_val(load_val),
    .auto_reload(auto_reload),
    .pause(pause),
    .abort(abort),
    .count_out(count_out),
    .tick(tick),
    .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step(
    input logic       st,
    input logic [3:0] lv,
    input logic       ar,
    input logic       ps,
    input logic       ab,
    input logic       r,
    input logic [3:0] ec,
    input logic       et,
    input logic       ed,
    input logic       eb,
    input string      nm
  );
    @(negedge clk);
    start       = st;
    load_val    = lv;
    auto_reload = ar;
    pause       = ps;
    abort       = ab;
    rst         = r;
    exp_q.push_back({ec, et, ed, eb});
    name_q.push_back(nm);
  endtask

  task automatic idle(
    input logic [3:0] ec,
    input logic       et,
    input logic       ed,
    input logic       eb,
    input string      nm
  );
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, ec, et, ed, eb, nm);
  endtask

  initial begin : monitor
    logic [6:0] e;
    logic [6:0] a;
    string      nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {count_out, tick, done, busy};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL %s: got cnt=%0d tick=%b done=%b busy=%b want cnt=%0d tick=%b done=%b busy=%b",
                   nm, a[6:3], a[2], a[1], a[0], e[6:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int waits;
    step(0, 4'd0, 0, 0, 0, 1, 4'd0, 0, 0, 0, "reset0");
    step(0, 4'd0, 0, 0, 0, 1, 4'd0, 0, 0, 0, "reset1");
    idle(4'd0, 0, 0, 0, "idle");

    step(1, 4'd3, 0, 0, 0, 0, 4'd3, 0, 0, 1, "t1_load3");
    idle(4'd2, 0, 0, 1, "t1_c2");
    idle(4'd1, 0, 0, 1, "t1_c1");
    idle(4'd0, 1, 0, 1, "t1_tick");
    idle(4'd0, 0, 1, 0, "t1_done");
    idle(4'd0, 0, 1, 0, "t1_done_hold");

    step(1, 4'd2, 1, 0, 0, 0, 4'd2, 0, 0, 1, "t2_load2");
    step(0, 4'd0, 1, 0, 0, 0, 4'd1, 0, 0, 1, "t2_c1");
    step(0, 4'd0, 1, 0, 0, 0, 4'd0, 1, 0, 1, "t2_tick_a");
    step(0, 4'd0, 1, 0, 0, 0, 4'd2, 0, 0, 1, "t2_reload");
    step(0, 4'd0, 1, 0, 0, 0, 4'd1, 0, 0, 1, "t2_c1b");
    step(0, 4'd0, 0, 0, 0, 0, 4'd0, 1, 0, 1, "t2_tick_b");
    idle(4'd0, 0, 1, 0, "t2_done");

    step(1, 4'd9, 0, 0, 0, 0, 4'd9, 0, 0, 1, "t3_load9");
    idle(4'd8, 0, 0, 1, "t3_c8");
    idle(4'd7, 0, 0, 1, "t3_c7");
    idle(4'd6, 0, 0, 1, "t3_c6");
    idle(4'd5, 0, 0, 1, "t3_c5");
    step(0, 4'd0, 0, 1, 0, 0, 4'd5, 0, 0, 1, "t3_pause_a");
    step(0, 4'd0, 0, 1, 0, 0, 4'd5, 0, 0, 1, "t3_pause_b");
    idle(4'd5, 0, 0, 1, "t3_resume");
    idle(4'd4, 0, 0, 1, "t3_c4");
    idle(4'd3, 0, 0, 1, "t3_c3");
    idle(4'd2, 0, 0, 1, "t3_c2");
    idle(4'd1, 0, 0, 1, "t3_c1");
    idle(4'd0, 1, 0, 1, "t3_tick");
    step(0, 4'd0, 0, 1, 0, 0, 4'd0, 0, 1, 0, "t3_pause_at_zero");
    step(0, 4'd0, 0, 1, 0, 0, 4'd0, 0, 1, 0, "t3_no_double_tick");

    step(1, 4'd0, 0, 0, 0, 0, 4'd0, 1, 0, 1, "t4_load0_tick");
    idle(4'd0, 0, 1, 0, "t4_done");
    step(1, 4'd15, 0, 0, 0, 0, 4'd15, 0, 0, 1, "t4_load15");
    idle(4'd14, 0, 0, 1, "t4_c14");
    idle(4'd13, 0, 0, 1, "t4_c13");

    step(1, 4'd2, 0, 0, 0, 0, 4'd12, 0, 0, 1, "t5_start_ignored");
    for (int i = 11; i >= 4; i--) begin
      idle(4'(i), 0, 0, 1, "t5_count");
    end
    step(0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0, 0, "t5_abort");
    idle(4'd0, 0, 0, 0, "t5_idle");

    step(1, 4'd1, 1, 0, 0, 0, 4'd1, 0, 0, 1, "t5_load1");
    step(1, 4'd3, 1, 0, 0, 0, 4'd0, 1, 0, 1, "t5_tick_restart");
    step(0, 4'd0, 1, 0, 0, 0, 4'd1, 0, 0, 1, "t5_reload_kept");
    step(0, 4'd0, 0, 0, 0, 0, 4'd0, 1, 0, 1, "t5_tick2");
    idle(4'd0, 0, 1, 0, "t5_done");

    step(1, 4'd0, 1, 0, 0, 0, 4'd0, 1, 0, 1, "p0_tick_a");
    step(0, 4'd0, 1, 0, 0, 0, 4'd0, 1, 0, 1, "p0_tick_b");
    step(0, 4'd0, 1, 0, 0, 0, 4'd0, 1, 0, 1, "p0_tick_c");
    step(0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 1, 0, "p0_done");
    step(0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0, 0, "abort_done");

    step(1, 4'd9, 0, 0, 0, 0, 4'd9, 0, 0, 1, "t6_load9");
    idle(4'd8, 0, 0, 1, "t6_c8");
    idle(4'd7, 0, 0, 1, "t6_c7");
    step(0, 4'd0, 0, 1, 0, 0, 4'd7, 0, 0, 1, "t6_paused");
    step(0, 4'd0, 0, 1, 0, 1, 4'd0, 0, 0, 0, "t6_rst_paused");
    idle(4'd0, 0, 0, 0, "t6_after_rst");

    step(1, 4'd6, 0, 0, 0, 0, 4'd6, 0, 0, 1, "t6_load6");
    idle(4'd5, 0, 0, 1, "t6_c5");
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    idle(4'd4, 0, 0, 1, "t6_glitch_ignored");
    step(1, 4'd5, 0, 0, 1, 0, 4'd0, 0, 0, 0, "abort_over_start");
    step(1, 4'd2, 0, 0, 0, 1, 4'd0, 0, 0, 0, "rst_over_start");
    step(1, 4'd2, 0, 0, 0, 0, 4'd2, 0, 0, 1, "start_after_rst");
    idle(4'd1, 0, 0, 1, "final_c1");

    waits = 0;
    while (exp_q.size() > 0 && waits < 20) begin
      @(posedge clk);
      waits++;
    end
    #2;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
